// File: rtl/hazard_scoreboard.sv
// Per-register write scoreboard beside ID: RAW / branch-in-ID / WAW stall with cause code.
// Optional stall-cycle counter is built only when HAZARD_SCOREBOARD_PERF_EN is defined.

module hsb_entry #(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             load_wait,
  input  logic [LAT_W-1:0] load_val,
  input  logic             cmpl_hit,
  output logic [LAT_W-1:0] cnt,
  output logic             wt
);
  // A new issue to this register is the younger write, so it overrides a completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      wt  <= 1'b0;
    end else if (load) begin
      cnt <= load_wait ? '0 : load_val;
      wt  <= load_wait;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (cmpl_hit)  wt  <= 1'b0;
    end
  end
endmodule

module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int LAT_W    = 4,
  parameter int BR_EXTRA = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic                issue_rs1_used,
  input  logic                issue_rs2_used,
  input  logic                issue_is_branch,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_rd_wen,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic                flush,
  input  logic                cmpl_valid,
  input  logic [ADDR_W-1:0]   cmpl_rd,
  output logic                stall,
  output logic [1:0]          stall_cause,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [31:0]         perf_stall_cnt,
  input  logic                perf_clr
);
  localparam int NIDX = 2**ADDR_W;
  localparam logic [LAT_W-1:0] BRX = LAT_W'(BR_EXTRA);

  // Full index space; x0 and indices past NUM_REGS read as permanently idle.
  logic [NIDX-1:0][LAT_W-1:0] cnt_a;
  logic [NIDX-1:0]            wt_a;

  logic [LAT_W:0]   lat_ext;
  logic [LAT_W-1:0] load_val;
  logic             fire;

  assign lat_ext  = {1'b0, issue_lat} + (LAT_W+1)'(BR_EXTRA);
  assign load_val = lat_ext[LAT_W] ? '1 : lat_ext[LAT_W-1:0];

  for (genvar r = 0; r < NIDX; r++) begin : g_reg
    if (r == 0 || r >= NUM_REGS) begin : g_none
      assign cnt_a[r] = '0;
      assign wt_a[r]  = 1'b0;
    end else begin : g_ent
      hsb_entry #(.LAT_W(LAT_W)) u_ent (
        .clk       (clk),
        .rst       (rst),
        .load      (fire && issue_rd == ADDR_W'(r)),
        .load_wait (issue_lat == '0),
        .load_val  (load_val),
        .cmpl_hit  (cmpl_valid && cmpl_rd == ADDR_W'(r)),
        .cnt       (cnt_a[r]),
        .wt        (wt_a[r])
      );
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_busy
    assign busy_vec[r] = !rst && (wt_a[r] || cnt_a[r] != '0);
  end

  logic [LAT_W-1:0] c1, c2, cd;
  logic             w1, w2, wd;
  logic             chk, s1_on, s2_on, raw, brh, waw;

  assign c1 = cnt_a[issue_rs1];
  assign c2 = cnt_a[issue_rs2];
  assign cd = cnt_a[issue_rd];
  assign w1 = wt_a[issue_rs1];
  assign w2 = wt_a[issue_rs2];
  assign wd = wt_a[issue_rd];

  assign chk   = issue_valid && !flush && !rst;
  assign s1_on = chk && issue_rs1_used && issue_rs1 != '0;
  assign s2_on = chk && issue_rs2_used && issue_rs2 != '0;

  // cnt <= BR_EXTRA is covered by EX forwarding, but not for a branch resolving in ID.
  assign raw = (s1_on && (w1 || c1 > BRX)) || (s2_on && (w2 || c2 > BRX));
  assign brh = issue_is_branch &&
               ((s1_on && c1 != '0 && c1 <= BRX) || (s2_on && c2 != '0 && c2 <= BRX));
  assign waw = chk && issue_rd_wen && issue_rd != '0 &&
               (wd || (issue_lat != '0 && {1'b0, cd} > lat_ext));

  always_comb begin
    stall       = raw || brh || waw;
    stall_cause = 2'd0;
    if (raw)      stall_cause = 2'd1;
    else if (brh) stall_cause = 2'd2;
    else if (waw) stall_cause = 2'd3;
  end

  assign fire = issue_valid && !stall && !flush && issue_rd_wen && issue_rd != '0;

`ifdef HAZARD_SCOREBOARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || perf_clr)                  perf_stall_cnt <= '0;
    else if (stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_stall_cnt  = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard at default parameters.
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_rs1_used, issue_rs2_used, issue_is_branch, issue_rd_wen;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, cmpl_rd;
  logic [3:0]  issue_lat;
  logic        flush, cmpl_valid, perf_clr;
  logic        stall;
  logic [1:0]  stall_cause;
  logic [31:0] busy_vec, perf_stall_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_is_branch(issue_is_branch), .issue_rd(issue_rd), .issue_rd_wen(issue_rd_wen),
    .issue_lat(issue_lat), .flush(flush), .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd),
    .stall(stall), .stall_cause(stall_cause), .busy_vec(busy_vec),
    .perf_stall_cnt(perf_stall_cnt), .perf_clr(perf_clr)
  );

  typedef struct {
    logic rst, v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2, br;
    logic [4:0] rd; logic wen; logic [3:0] lat; logic fl, cv; logic [4:0] crd;
    logic es; logic [1:0] ec; logic [31:0] eb;
  } vec_t;

  vec_t tv[$];
  int   n_chk = 0, n_fail = 0, n_proto = 0;

  task automatic add(input logic rs, v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, br, input logic [4:0] rd,
                     input logic wen, input logic [3:0] lat, input logic fl, cv,
                     input logic [4:0] crd, input logic es, input logic [1:0] ec,
                     input logic [31:0] eb);
    vec_t t;
    t = '{rs, v, rs1, u1, rs2, u2, br, rd, wen, lat, fl, cv, crd, es, ec, eb};
    tv.push_back(t);
  endtask

  task automatic idle(input logic [31:0] eb);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eb);
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; issue_valid = t.v; issue_rs1 = t.rs1; issue_rs1_used = t.u1;
    issue_rs2 = t.rs2; issue_rs2_used = t.u2; issue_is_branch = t.br;
    issue_rd = t.rd; issue_rd_wen = t.wen; issue_lat = t.lat; flush = t.fl;
    cmpl_valid = t.cv; cmpl_rd = t.crd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Completions must target a register with a variable-latency write outstanding.
  always @(posedge clk)
    if (!rst && cmpl_valid && cmpl_rd != 5'd0 && !busy_vec[cmpl_rd]) begin
      n_proto++;
      $display("protocol: completion on idle register x%0d", cmpl_rd);
    end

  initial begin
    vec_t t;
    perf_clr = 1'b0;
    // reset
    add(1, 1, 5, 1, 0, 0, 0, 5, 1, 3, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use lat=1: reader sees cnt=1, forwarded
    add(0, 1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(32'h20);
    add(0, 1, 5, 1, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 32'h20);
    idle(32'h40); idle(32'h40);
    // load-use lat=2: one RAW stall cycle on rs2
    add(0, 1, 0, 0, 0, 0, 0, 5, 1, 2, 0, 0, 0, 0, 0, 0);
    idle(32'h20);
    add(0, 1, 0, 0, 5, 1, 0, 6, 1, 1, 0, 0, 0, 1, 1, 32'h20);
    add(0, 1, 0, 0, 5, 1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 32'h20);
    idle(32'h40); idle(32'h40);
    // branch in ID on cnt=1
    add(0, 1, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(32'h8);
    add(0, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2, 32'h8);
    add(0, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // divider x7, completion visible one cycle later
    add(0, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 7, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0, 1, 1, 32'h80);
    add(0, 1, 7, 1, 0, 0, 0, 8, 1, 1, 0, 1, 7, 1, 1, 32'h80);
    add(0, 1, 7, 1, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    idle(32'h100); idle(32'h100);
    // WAW on pending divider; then issue+completion coincide on x9
    add(0, 1, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1, 3, 32'h200);
    add(0, 1, 0, 0, 0, 0, 0, 9, 1, 1, 0, 1, 9, 1, 3, 32'h200);
    add(0, 1, 0, 0, 0, 0, 0, 9, 1, 0, 0, 1, 9, 0, 0, 0);
    idle(32'h200); idle(32'h200);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h200);
    idle(0);
    // WAW against a long fixed-latency write: cnt 6..3 stalls, 2 issues
    add(0, 1, 0, 0, 0, 0, 0, 9, 1, 5, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1, 3, 32'h200);
    add(0, 1, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 32'h200);
    idle(32'h200); idle(32'h200);
    // x0 never tracked, x0 sources never checked
    add(0, 1, 0, 1, 0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
    idle(0);
    // saturation (15+1 -> 15), RAW over BRANCH/WAW, then flush
    add(0, 1, 0, 0, 0, 0, 0, 10, 1, 15, 0, 0, 0, 0, 0, 0);
    add(0, 1, 10, 1, 0, 0, 1, 10, 1, 1, 0, 0, 0, 1, 1, 32'h400);
    add(0, 1, 10, 1, 0, 0, 1, 11, 1, 3, 1, 0, 0, 0, 0, 32'h400);
    idle(32'h400);

    foreach (tv[i]) begin
      @(negedge clk);
      t = tv[i];
      drive(t);
      #1;
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(t.es));
      chk($sformatf("v%0d cause", i), 32'(stall_cause), 32'(t.ec));
      chk($sformatf("v%0d busy", i), busy_vec, t.eb);
    end

    // x10 loaded with 15 drains to 1 after twelve more edges, then 0
    repeat (12) @(negedge clk);
    #1 chk("sat_drain_1", busy_vec, 32'h400);
    @(negedge clk); #1 chk("sat_drain_0", busy_vec, 32'h0);

    // reset mid-operation discards a pending divider
    @(negedge clk);
    issue_valid = 1; issue_rd = 4; issue_rd_wen = 1; issue_lat = 0;
    @(negedge clk);
    issue_valid = 0; issue_rd_wen = 0;
    #1 chk("pend_x4", busy_vec, 32'h10);
    @(negedge clk); rst = 1;
    #1 chk("rst_busy", busy_vec, 32'h0);
    @(negedge clk); rst = 0;
    issue_valid = 1; issue_rs1 = 4; issue_rs1_used = 1;
    #1 chk("post_rst_stall", 32'(stall), 32'd0);
    chk("post_rst_busy", busy_vec, 32'h0);
    @(negedge clk); issue_valid = 0; issue_rs1_used = 0;

`ifdef HAZARD_SCOREBOARD_PERF_EN
    perf_clr = 1;
    @(negedge clk); perf_clr = 0;
    #1 chk("perf_clr0", perf_stall_cnt, 32'd0);
    @(negedge clk);
    issue_valid = 1; issue_rd = 12; issue_rd_wen = 1; issue_lat = 0;
    @(negedge clk);
    issue_rd_wen = 0; issue_rs1 = 12; issue_rs1_used = 1;
    repeat (5) @(negedge clk);
    issue_valid = 0; issue_rs1_used = 0; cmpl_valid = 1; cmpl_rd = 12;
    #1 chk("perf_5", perf_stall_cnt, 32'd5);
    @(negedge clk); cmpl_valid = 0; perf_clr = 1;
    @(negedge clk); perf_clr = 0;
    #1 chk("perf_clr1", perf_stall_cnt, 32'd0);
`else
    #1 chk("perf_tied0", perf_stall_cnt, 32'd0);
`endif

    chk("protocol_count", 32'(n_proto), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
